// File: rtl/ultrasonic_echo_responder.sv
// Target-side emulation of an HC-SR04 style ranger: answers each valid trigger
// pulse with an echo whose width encodes the programmed distance.
module ultrasonic_echo_responder #(
   parameter int CLK_DIV       = 27,
   parameter int TRIG_MIN_US   = 10,
   parameter int ECHO_DELAY_US = 450,
   parameter int MAX_CM        = 400,
   parameter int TIMEOUT_US    = 38000,
   parameter int HOLDOFF_US    = 10000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       trigger,
   input  logic [8:0] distance_cm,
   input  logic       obstacle,
   output logic       echo,
   output logic       busy,
   output logic [7:0] accept_cnt,
   output logic [7:0] reject_cnt
);

   // state     | meaning
   // S_IDLE    | waiting for a fresh trigger rising edge
   // S_TRIG_HI | measuring trigger high width
   // S_DELAY   | burst emulation delay before echo
   // S_ECHO    | echo high for width_us
   // S_HOLDOFF | dead time, new triggers rejected
   typedef enum logic [2:0] {S_IDLE, S_TRIG_HI, S_DELAY, S_ECHO, S_HOLDOFF} state_t;

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t        r_state, w_next;
   logic          r_sync1, r_trig_s, r_trig_d;
   logic [PW-1:0] r_pre;
   logic [15:0]   r_us_cnt, r_width_us;
   logic          r_echo;
   logic [7:0]    r_acc, r_rej;

   logic          w_rise, w_fall, w_tick, w_change;
   logic          w_accept, w_reject, w_echo_set, w_echo_clr;
   logic [14:0]   w_d15, w_prod;
   logic          w_no_target;
   logic [15:0]   w_width;

   assign w_rise   = r_trig_s & ~r_trig_d;
   assign w_fall   = ~r_trig_s & r_trig_d;
   assign w_tick   = (r_pre == PW'(CLK_DIV - 1));
   assign w_change = (w_next != r_state);

   // d*58 = d*64 - d*4 - d*2; fits 15 bits for d <= 400
   assign w_d15       = {6'd0, distance_cm};
   assign w_prod      = (w_d15 << 6) - (w_d15 << 2) - (w_d15 << 1);
   assign w_no_target = ~obstacle | (distance_cm == 9'd0) | (int'(distance_cm) > MAX_CM);
   assign w_width     = w_no_target ? 16'(TIMEOUT_US) : {1'b0, w_prod};

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_reject   = 1'b0;
      w_echo_set = 1'b0;
      w_echo_clr = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise) w_next = S_TRIG_HI;
         end
         S_TRIG_HI: begin
            if (w_fall) begin
               if (r_us_cnt >= 16'(TRIG_MIN_US)) begin
                  w_next   = S_DELAY;
                  w_accept = 1'b1;
               end else begin
                  w_next   = S_IDLE;
                  w_reject = 1'b1;
               end
            end
         end
         S_DELAY: begin
            w_reject = w_rise;
            if (w_tick && r_us_cnt == 16'(ECHO_DELAY_US - 1)) begin
               w_next     = S_ECHO;
               w_echo_set = 1'b1;
            end
         end
         S_ECHO: begin
            w_reject = w_rise;
            if (w_tick && r_us_cnt == r_width_us - 16'd1) begin
               w_next     = S_HOLDOFF;
               w_echo_clr = 1'b1;
            end
         end
         S_HOLDOFF: begin
            w_reject = w_rise;
            if (w_tick && r_us_cnt == 16'(HOLDOFF_US - 1)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync1    <= 1'b0;
         r_trig_s   <= 1'b0;
         r_trig_d   <= 1'b0;
         r_pre      <= '0;
         r_us_cnt   <= '0;
         r_width_us <= '0;
         r_echo     <= 1'b0;
         r_acc      <= '0;
         r_rej      <= '0;
      end else begin
         r_sync1  <= trigger;
         r_trig_s <= r_sync1;
         r_trig_d <= r_trig_s;
         // prescaler and timer restart on every state change so intervals are exact
         if (w_change || w_tick) r_pre <= '0;
         else                    r_pre <= r_pre + PW'(1);
         if (w_change) r_us_cnt <= '0;
         else if (w_tick && !(r_state == S_TRIG_HI && r_us_cnt >= 16'(TRIG_MIN_US)))
            r_us_cnt <= r_us_cnt + 16'd1;
         if (w_accept)   r_width_us <= w_width;
         if (w_accept)   r_acc <= r_acc + 8'd1;
         if (w_reject)   r_rej <= r_rej + 8'd1;
         if (w_echo_set) r_echo <= 1'b1;
         else if (w_echo_clr) r_echo <= 1'b0;
      end
   end

   assign echo       = r_echo;
   assign busy       = (r_state != S_IDLE) && (r_state != S_TRIG_HI);
   assign accept_cnt = r_acc;
   assign reject_cnt = r_rej;

endmodule
